// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch block: FSM states, decoded opcodes
// and the program image loaded into program memory at elaboration.
package instr_fetch_pkg;

  localparam int unsigned MAX_DEPTH = 256;

  localparam logic [7:0] HALT_OP = 8'h13;
  localparam logic [7:0] NOP_OP  = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT_ST
  } state_e;

  // Word i of the image lives in element [i]; memories take the low DEPTH words.
  typedef logic [MAX_DEPTH-1:0][7:0] image_t;

  localparam image_t DEFAULT_PROGRAM = {
    {(MAX_DEPTH-4){NOP_OP}},
    8'h2A,
    HALT_OP,
    8'h01,
    NOP_OP
  };

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Synchronous-read program memory. Defining INSTR_FETCH_LOAD_EN enables the
// write port; otherwise the memory is read-only and the write inputs are ignored.
module prog_mem
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter image_t      INIT_IMAGE = DEFAULT_PROGRAM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i
);

  // NOTE: the array has no reset; its contents come only from INIT_IMAGE and writes.
  logic [DEPTH-1:0][7:0] mem_q = INIT_IMAGE[DEPTH-1:0];
  logic [7:0]            rdata_q;

`ifdef INSTR_FETCH_LOAD_EN
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`else
  logic unused_write;
  assign unused_write = ^{we_i, waddr_i, wdata_i};
`endif

  // The read register holds its word whenever re_i is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= NOP_OP;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM and PC in front of prog_mem. INSTR_FETCH_LOAD_EN enables
// program loading while the FSM is in IDLE or HALT_ST.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter image_t      INIT_IMAGE = DEFAULT_PROGRAM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic              busy_q;
  logic              halted_q;
  logic              mem_we;

  // Loads are only allowed while no fetch is in flight.
  assign mem_we = load_we && (state_q == IDLE || state_q == HALT_ST);

  prog_mem #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_prog_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .re_i    (state_q == FETCH),
    .raddr_i (pc_q),
    .rdata_o (instr),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT_ST: begin
          if (start) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        FETCH: begin
          state_q <= ISSUE;
          valid_q <= 1'b1;
        end
        ISSUE: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            if (instr == HALT_OP) begin
              state_q  <= HALT_ST;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH;
              pc_q    <= pc_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign busy        = busy_q;

endmodule
